// File: rtl/prio_sel_pkg.sv
// Shared helpers for the rotating priority select: index modulo and bit-vector rotation.
// Vectors are carried at the maximum supported width; callers truncate to their own width.
package prio_sel_pkg;

    localparam int unsigned MaxWidth = 64;

    typedef logic [MaxWidth-1:0] vec_t;

    function automatic int unsigned idx_mod(input int unsigned i, input int unsigned width);
        return i % width;
    endfunction

    // Bit i of the result takes bit (i + amt) mod width of v; bits at or above width are zero.
    function automatic vec_t rotr(input vec_t v, input int unsigned width,
                                  input int unsigned amt);
        vec_t r;
        r = '0;
        for (int unsigned i = 0; i < MaxWidth; i++) begin
            if (i < width) begin
                r[i] = v[6'(idx_mod(i + amt, width))];
            end
        end
        return r;
    endfunction

    function automatic vec_t rotl(input vec_t v, input int unsigned width,
                                  input int unsigned amt);
        return rotr(v, width, idx_mod(width - idx_mod(amt, width), width));
    endfunction

endpackage

// File: rtl/rr_priority_select_if.sv
// Request/grant bundle between requesters, the select block and the grant consumer.
// The select block uses the slave modport; the stimulus/consumer side uses master.
interface rr_priority_select_if #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned NUM_GRANTS = 2
);
    localparam int unsigned IDX_W = $clog2(WIDTH);
    localparam int unsigned CNT_W = $clog2(NUM_GRANTS + 1);

    logic [WIDTH-1:0]                 req;
    logic                             out_ready;
    logic                             out_valid;
    logic [NUM_GRANTS-1:0][IDX_W-1:0] grant_idx;
    logic [NUM_GRANTS-1:0]            grant_vld;
    logic [WIDTH-1:0]                 grant_mask;
    logic [CNT_W-1:0]                 grant_cnt;

    modport master (
        output req,
        output out_ready,
        input  out_valid,
        input  grant_idx,
        input  grant_vld,
        input  grant_mask,
        input  grant_cnt
    );

    modport slave (
        input  req,
        input  out_ready,
        output out_valid,
        output grant_idx,
        output grant_vld,
        output grant_mask,
        output grant_cnt
    );

endinterface

// File: rtl/priority_decoder.sv
// Highest-set-bit decoder: one-hot, index and valid for the top-most set bit of req_i.
module priority_decoder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0]         req_i,
    output logic [WIDTH-1:0]         onehot_o,
    output logic [$clog2(WIDTH)-1:0] idx_o,
    output logic                     vld_o
);

    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        vld_o    = 1'b0;
        // Ascending scan: the last set bit seen, i.e. the highest, wins.
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (req_i[i]) begin
                onehot_o    = '0;
                onehot_o[i] = 1'b1;
                idx_o       = $clog2(WIDTH)'(i);
                vld_o       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_priority_select.sv
// Round-robin multi-grant select: up to NUM_GRANTS requesters per transfer, registered outputs.
// Define RR_PRIORITY_SELECT_FIXED_EN for fixed highest-index-first priority with no pointer.
module rr_priority_select
    import prio_sel_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned NUM_GRANTS = 2
) (
    input logic                 clk,
    input logic                 rst,
    rr_priority_select_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(WIDTH);
    localparam int unsigned CNT_W = $clog2(NUM_GRANTS + 1);

    logic                             load;
    logic [IDX_W-1:0]                 ptr;
    int unsigned                      shamt;
    logic [WIDTH-1:0]                 rot_req;

    logic [NUM_GRANTS-1:0][WIDTH-1:0] dec_oh;
    logic [NUM_GRANTS-1:0][IDX_W-1:0] dec_idx;
    logic [NUM_GRANTS-1:0]            dec_vld;

    logic                             out_valid_q;
    logic [NUM_GRANTS-1:0][IDX_W-1:0] grant_idx_d,  grant_idx_q;
    logic [NUM_GRANTS-1:0]            grant_vld_d,  grant_vld_q;
    logic [WIDTH-1:0]                 grant_mask_d, grant_mask_q;
    logic [CNT_W-1:0]                 grant_cnt_d,  grant_cnt_q;

    assign load = !out_valid_q || bus.out_ready;

`ifdef RR_PRIORITY_SELECT_FIXED_EN
    assign ptr = IDX_W'(WIDTH - 1);
`else
    logic [IDX_W-1:0] ptr_q, ptr_d;

    assign ptr = ptr_q;

    // Next search starts just below the last requester granted in this transfer.
    always_comb begin
        ptr_d = ptr_q;
        for (int unsigned k = 0; k < NUM_GRANTS; k++) begin
            if (dec_vld[k]) begin
                ptr_d = IDX_W'(idx_mod(32'(grant_idx_d[k]) + WIDTH - 1, WIDTH));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= IDX_W'(WIDTH - 1);
        end else if (load) begin
            ptr_q <= ptr_d;
        end
    end
`endif

    // Rotate so requester ptr lands on the top bit; descending bit order is then priority order.
    assign shamt   = idx_mod(32'(ptr) + 1, WIDTH);
    assign rot_req = WIDTH'(rotr(vec_t'(bus.req), WIDTH, shamt));

    for (genvar k = 0; k < NUM_GRANTS; k++) begin : g_slot
        logic [WIDTH-1:0] taken;
        logic [WIDTH-1:0] oh;

        if (k == 0) begin : g_first
            assign taken = '0;
        end else begin : g_rest
            assign taken = g_slot[k-1].taken | g_slot[k-1].oh;
        end

        priority_decoder #(
            .WIDTH (WIDTH)
        ) u_dec (
            .req_i    (rot_req & ~taken),
            .onehot_o (oh),
            .idx_o    (dec_idx[k]),
            .vld_o    (dec_vld[k])
        );

        assign dec_oh[k] = oh;
    end

    always_comb begin
        grant_idx_d  = '0;
        grant_vld_d  = '0;
        grant_mask_d = '0;
        grant_cnt_d  = '0;
        for (int unsigned k = 0; k < NUM_GRANTS; k++) begin
            if (dec_vld[k]) begin
                grant_vld_d[k] = 1'b1;
                grant_idx_d[k] = IDX_W'(idx_mod(32'(dec_idx[k]) + shamt, WIDTH));
                grant_mask_d   = grant_mask_d | WIDTH'(rotl(vec_t'(dec_oh[k]), WIDTH, shamt));
                grant_cnt_d    = grant_cnt_d + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            grant_idx_q  <= '0;
            grant_vld_q  <= '0;
            grant_mask_q <= '0;
            grant_cnt_q  <= '0;
        end else if (load) begin
            out_valid_q  <= |bus.req;
            grant_idx_q  <= grant_idx_d;
            grant_vld_q  <= grant_vld_d;
            grant_mask_q <= grant_mask_d;
            grant_cnt_q  <= grant_cnt_d;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.grant_idx  = grant_idx_q;
    assign bus.grant_vld  = grant_vld_q;
    assign bus.grant_mask = grant_mask_q;
    assign bus.grant_cnt  = grant_cnt_q;

endmodule

// File: doc/rr_priority_select.md
RR_PRIORITY_SELECT -- requirements
Module: rr_priority_select

Interface
REQ-001 SHALL have parameter WIDTH, default 8, number of request lines; legal range 2..64.
REQ-002 SHALL have parameter NUM_GRANTS, default 2, maximum grants per transfer; legal range 1..WIDTH.
REQ-003 SHALL define localparams IDX_W = $clog2(WIDTH) and CNT_W = $clog2(NUM_GRANTS+1).
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset that is synchronous and active-high.
REQ-006 SHALL have port req, input, WIDTH, level request vector, where bit i is requester i.
REQ-007 SHALL have port out_ready, input, 1, consumer accepts the current grant set.
REQ-008 SHALL have port out_valid, output, 1, registered grant set valid.
REQ-009 SHALL have port grant_idx, output, NUM_GRANTS x IDX_W, granted indices with slot 0 the highest priority.
REQ-010 SHALL have port grant_vld, output, NUM_GRANTS, per-slot valid.
REQ-011 SHALL have port grant_mask, output, WIDTH, OR of one-hot encodings of all valid slots.
REQ-012 SHALL have port grant_cnt, output, CNT_W, number of valid slots.

Function
REQ-013 SHALL define load = !out_valid || out_ready; req is sampled only on cycles where load is high.
REQ-014 SHALL define priority order from pointer ptr descending with wrap: ptr, ptr-1, ..., 0, WIDTH-1, ..., ptr+1.
REQ-015 SHALL, on load, fill slot k with the k-th set bit of req in priority order; slots beyond popcount(req) SHALL have grant_vld=0 and grant_idx=0.
REQ-016 SHALL register all outputs, giving one-cycle latency from sampled req to out_valid/grant fields.
REQ-017 SHALL, on load, set out_valid to |req, so that req=0 yields out_valid=0 next cycle.
REQ-018 SHALL hold every output bit-stable and ignore req while out_valid && !out_ready (stall).
REQ-019 SHALL, on load with at least one grant, set ptr to (last valid slot index - 1) mod WIDTH, so that index 0 wraps to WIDTH-1; ptr SHALL be unchanged when there are no grants or during a stall.
REQ-020 SHALL grant each requester at most once per transfer; grant_cnt SHALL equal popcount(grant_vld) and min(popcount(req), NUM_GRANTS).
REQ-021 SHALL hold no other state; there is no FSM beyond out_valid and ptr.

Reset
REQ-022 SHALL, on rst, clear out_valid, grant_vld, grant_idx, grant_mask and grant_cnt to 0, and set ptr to WIDTH-1.
REQ-023 SHALL give rst priority over load and stall, abandoning a stalled grant set and producing no output on the following cycle.

Configuration
REQ-024 SHALL, with macro RR_PRIORITY_SELECT_FIXED_EN defined, compile out ptr and tie priority to fixed highest-index-first order (WIDTH-1 down to 0).
REQ-025 SHALL, without RR_PRIORITY_SELECT_FIXED_EN defined, operate as the rotating round-robin select of REQ-014 and REQ-019.

Structure
REQ-026 SHALL place a rotate-left/rotate-right helper function and its index-modulo function in shared package prio_sel_pkg; width localparams stay in the module.
REQ-027 SHALL build each grant slot from sub-module priority_decoder (WIDTH param), applied to the rotated req with previously granted bits masked, then un-rotated by ptr.

Verification (WIDTH=4, NUM_GRANTS=2, round-robin unless noted)
REQ-028 SHALL verify reset with req=0000: out_valid=0, grant_cnt=0, and internal ptr=3.
REQ-029 SHALL verify req=0110 with out_ready=1: next cycle grant_idx={2,1}, grant_vld=11, grant_mask=0110, grant_cnt=2, and ptr becomes 0.
REQ-030 SHALL verify that req=1111 applied after REQ-029 gives next grant_idx={0,3}, grant_mask=1001, and ptr becomes 2.
REQ-031 SHALL verify a stall: with out_ready=0, changing req to 0001 for 3 cycles leaves outputs unchanged; raising out_ready then loads slot 0=0, grant_vld=01, grant_cnt=1.
REQ-032 SHALL verify that with RR_PRIORITY_SELECT_FIXED_EN defined, req=1111 repeated 3 times returns {3,2} every transfer, and req=0001 returns slot 0=0 with grant_cnt=1.
REQ-033 SHALL verify that rst asserted mid-stall gives out_valid=0 next cycle, and a following req=1111 gives grant_idx={3,2}.
